// File: rtl/spi_pkg.sv
// Shared constants, state type and frame builder for the write-only SPI controller
// and for any peripheral-side receiver that decodes its frames.
package spi_pkg;

  localparam int       MAX_ADDR  = 4;
  localparam int       ADDR_W    = 7;
  localparam int       DATA_W    = 8;
  localparam int       FRAME_W   = 16;
  localparam logic     WRITE_BIT = 1'b1;
  localparam int       BIT_CNT_W = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_e;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    return {WRITE_BIT, addr, data};
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period pacer: counts CLK_DIV system clocks while enabled and flags each
// half-period boundary, classified as a rising or falling SCLK edge.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic sclk_i,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign rise_o = tick_o && !sclk_i;
  assign fall_o = tick_o &&  sclk_i;

  // NOTE: registers update with <= so every flop samples values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 register-write master: one 16-bit frame {write, addr, data} per
// accepted request, with enforced nCS-high gap between frames.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_HALVES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              done,
  output logic              err,
  output logic              sclk,
  output logic              nCS,
  output logic              COPI
);

  localparam int GAP_W = $clog2(GAP_HALVES + 1);

  spi_state_e           state_q;
  logic [FRAME_W-1:0]   shift_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [GAP_W-1:0]     gap_cnt_q;
  logic                 sclk_q;
  logic                 ncs_q;
  logic                 copi_q;
  logic                 done_q;
  logic                 err_q;
  logic                 tick;
  logic                 rise;
  logic                 fall;
  logic                 accept;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  assign sclk = sclk_q;
  assign nCS  = ncs_q;
  assign COPI = copi_q;
  assign done = done_q;
  assign err  = err_q;

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q != IDLE),
    .sclk_i(sclk_q),
    .tick_o(tick),
    .rise_o(rise),
    .fall_o(fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      copi_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (req_addr > ADDR_W'(MAX_ADDR)) begin
              err_q <= 1'b1;
            end else begin
              shift_q   <= make_frame(req_addr, req_data);
              copi_q    <= WRITE_BIT;
              ncs_q     <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= SETUP;
            end
          end
        end
        SETUP: begin
          if (tick) state_q <= SHIFT;
        end
        SHIFT: begin
          // COPI follows the shifted MSB one cycle after the falling edge, so it
          // never moves in the same cycle as sclk.
          copi_q <= shift_q[FRAME_W-1];
          if (rise) begin
            sclk_q <= 1'b1;
          end else if (fall) begin
            sclk_q    <= 1'b0;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_CNT_W'(FRAME_W - 1)) begin
              state_q <= HOLD;
            end else begin
              shift_q <= shift_q << 1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            ncs_q     <= 1'b1;
            copi_q    <= 1'b0;
            done_q    <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            if (gap_cnt_q == GAP_W'(GAP_HALVES - 1)) begin
              gap_cnt_q <= '0;
              state_q   <= IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: timing model of the pins derived from the frame rules,
// a peripheral receiver decoding writes, and directed scenarios with literal expectations.
module tb_spi_controller;
  import spi_pkg::*;

  localparam int CD        = 4;
  localparam int GH        = 2;
  localparam int CD_B      = 2;
  localparam int FRAME_CYC = 34 * CD;
  localparam int BUSY_CYC  = (34 + GH) * CD;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [6:0] req_addr  = '0;
  logic [7:0] req_data  = '0;
  logic       req_ready, done, err, sclk, nCS, COPI;

  logic       req_valid_b = 1'b0;
  logic [6:0] req_addr_b  = '0;
  logic [7:0] req_data_b  = '0;
  logic       req_ready_b, done_b, err_b, sclk_b, ncs_b, copi_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(CD), .GAP_HALVES(GH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .done(done), .err(err),
    .sclk(sclk), .nCS(nCS), .COPI(COPI)
  );

  spi_controller #(.CLK_DIV(CD_B), .GAP_HALVES(GH)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr_b), .req_data(req_data_b), .done(done_b), .err(err_b),
    .sclk(sclk_b), .nCS(ncs_b), .COPI(copi_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of dut ----------------
  int          edge_n   = 0;
  bit          m_active = 1'b0;
  int          m_e0     = 0;
  int          m_err_e  = -100;
  int          m_acc    = 0;
  int          m_acc_e  = 0;
  logic [15:0] m_frame  = '0;
  bit          chk_en   = 1'b0;

  // Ready is low from the accepting edge until the gap has fully elapsed.
  function automatic bit m_ready_after(input int n);
    return !m_active || (n - m_e0) >= BUSY_CYC;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit rdy;
    if (!rst_n) begin
      m_active = 1'b0;
      m_err_e  = -100;
    end else begin
      rdy = m_ready_after(edge_n);
      edge_n++;
      if (req_valid && rdy) begin
        m_acc++;
        m_acc_e = edge_n;
        if (int'(req_addr) > MAX_ADDR) begin
          m_err_e = edge_n;
        end else begin
          m_active = 1'b1;
          m_e0     = edge_n;
          m_frame  = {1'b1, req_addr, req_data};
        end
      end
    end
  end

  // Half-period h after accept: 0 setup, 1..32 shift (sclk high on even h), 33 hold.
  always @(negedge clk) begin : compare
    int k, h, idx;
    bit in_f;
    if (rst_n && chk_en) begin
      k    = edge_n - m_e0;
      in_f = m_active && k >= 0 && k < FRAME_CYC;
      h    = k / CD;
      check("ready", req_ready, m_ready_after(edge_n));
      check("nCS",   nCS, !in_f);
      check("sclk",  sclk, in_f && h >= 2 && h <= 32 && (h % 2) == 0);
      check("done",  done, m_active && k == FRAME_CYC);
      check("err",   err, edge_n == m_err_e);
      if (in_f) begin
        idx = 15;
        for (int j = 1; j <= 15; j++) if (k >= (1 + 2 * j) * CD + 1) idx--;
        check("COPI", COPI, m_frame[idx]);
      end
    end
  end

  // ---------------- peripheral receivers ----------------
  logic [15:0] rx_sr_a = '0, rx_last_a = '0;
  int          rx_cnt_a = 0, rx_last_cnt_a = 0;
  logic [7:0]  regs_a [0:MAX_ADDR];
  int          ncs_fall_e = 0, ncs_rise_e = 0, nfall_a = 0, ndone_a = 0, done_e = -1, err_e = -1;

  always @(posedge sclk) if (!nCS) begin
    rx_sr_a = {rx_sr_a[14:0], COPI};
    rx_cnt_a++;
  end
  always @(negedge nCS) begin
    rx_cnt_a = 0;
    ncs_fall_e = edge_n;
    nfall_a++;
  end
  always @(posedge nCS) begin : rx_commit_a
    int a;
    ncs_rise_e    = edge_n;
    rx_last_cnt_a = rx_cnt_a;
    if (rx_cnt_a == FRAME_W) begin
      rx_last_a = rx_sr_a;
      a = int'(rx_sr_a[14:8]);
      if (rx_sr_a[15] == WRITE_BIT && a <= MAX_ADDR) regs_a[a] = rx_sr_a[7:0];
    end
  end
  always @(posedge done) begin ndone_a++; done_e = edge_n; end
  always @(posedge err) err_e = edge_n;

  logic [15:0] rx_sr_b = '0, rx_last_b = '0;
  int          rx_cnt_b = 0, rx_last_cnt_b = 0, rise1_b = 0, rise2_b = 0, done_b_e = -1;

  always @(posedge sclk_b) if (!ncs_b) begin
    rx_sr_b = {rx_sr_b[14:0], copi_b};
    rx_cnt_b++;
    if (rx_cnt_b == 1) rise1_b = edge_n;
    if (rx_cnt_b == 2) rise2_b = edge_n;
  end
  always @(negedge ncs_b) rx_cnt_b = 0;
  always @(posedge ncs_b) begin
    rx_last_cnt_b = rx_cnt_b;
    if (rx_cnt_b == FRAME_W) rx_last_b = rx_sr_b;
  end
  always @(posedge done_b) done_b_e = edge_n;

  // ---------------- stimulus ----------------
  task automatic send_a(input logic [6:0] a, input logic [7:0] d, input bit keep);
    int start, n;
    start = m_acc;
    n = 0;
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    while (m_acc == start && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("accept_seen", m_acc != start, 1);
    if (!keep) begin
      req_valid = 1'b0;
      req_addr  = 7'h7F;
      req_data  = 8'h00;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int f0, d0, acc_b;
    for (int i = 0; i <= MAX_ADDR; i++) regs_a[i] = 8'h00;

    idle_cycles(3);
    check("rst_nCS",  nCS, 1);
    check("rst_sclk", sclk, 0);
    check("rst_COPI", COPI, 0);
    check("rst_done", done, 0);
    check("rst_err",  err, 0);
    check("rst_nCS_b", ncs_b, 1);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);

    // Scenario 1: lowest address, alternating data pattern.
    done_e = -1;
    send_a(7'h00, 8'hA5, 1'b0);
    idle_cycles(BUSY_CYC + 4);
    check("s1_frame", rx_last_a, 16'h80A5);
    check("s1_rises", rx_last_cnt_a, 16);
    check("s1_done_latency_from_accept_edge", done_e - m_acc_e, 136);

    // Scenario 2: highest legal address.
    send_a(7'h04, 8'hFF, 1'b0);
    idle_cycles(BUSY_CYC + 4);
    check("s2_reg4", regs_a[4], 8'hFF);
    check("s2_rises", rx_last_cnt_a, 16);

    // Scenario 3: first out-of-range address is rejected.
    f0 = nfall_a;
    d0 = ndone_a;
    send_a(7'h05, 8'h12, 1'b0);
    idle_cycles(20);
    check("s3_err_cycle_after_accept_cycle", err_e - (m_acc_e - 1), 1);
    check("s3_no_nCS_fall", nfall_a - f0, 0);
    check("s3_no_done", ndone_a - d0, 0);
    check("s3_ready", req_ready, 1);

    // Scenario 4: valid held high across two queued requests.
    send_a(7'h01, 8'h11, 1'b1);
    send_a(7'h02, 8'h22, 1'b0);
    check("s4_gap_exact", ncs_fall_e - ncs_rise_e, GH * CD + 1);
    check("s4_gap_min", (ncs_fall_e - ncs_rise_e) >= GH * CD, 1);
    idle_cycles(BUSY_CYC + 4);
    check("s4_reg1", regs_a[1], 8'h11);
    check("s4_reg2", regs_a[2], 8'h22);

    // Scenario 5: reset mid-frame after the 7th rising sclk.
    d0 = ndone_a;
    send_a(7'h03, 8'h5A, 1'b0);
    f0 = 0;
    while (rx_cnt_a < 7 && f0 < 500) begin
      @(negedge clk);
      f0++;
    end
    check("s5_reached_7_rises", rx_cnt_a, 7);
    #2 rst_n = 1'b0;
    #1;
    check("s5_async_nCS", nCS, 1);
    check("s5_async_sclk", sclk, 0);
    check("s5_async_done", done, 0);
    idle_cycles(2);
    #2 rst_n = 1'b1;
    idle_cycles(FRAME_CYC);
    check("s5_no_done", ndone_a - d0, 0);
    check("s5_no_write", regs_a[3], 8'h00);
    send_a(7'h03, 8'h5A, 1'b0);
    idle_cycles(BUSY_CYC + 4);
    check("s5_next_frame", rx_last_a, 16'h835A);
    check("s5_reg3", regs_a[3], 8'h5A);

    // Scenario 6: fastest divider on the second instance (idle, so ready).
    req_addr_b  = 7'h03;
    req_data_b  = 8'h3C;
    req_valid_b = 1'b1;
    @(negedge clk);
    acc_b = edge_n;
    req_valid_b = 1'b0;
    idle_cycles((34 + GH) * CD_B + 4);
    check("s6_frame", rx_last_b, 16'h833C);
    check("s6_rises", rx_last_cnt_b, 16);
    check("s6_sclk_period", rise2_b - rise1_b, 4);
    check("s6_done_latency_from_accept_edge", done_b_e - acc_b, 68);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter: CLK_DIV, default 4, clk cycles per SCLK half-period (legal values 2..255).
REQ-002 Parameter: GAP_HALVES, default 2, nCS-high half-periods enforced between frames (legal values 1..15).
REQ-003 Port: clk  in  1  system clock; all state updates on its rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: req_valid  in  1  write request present.
REQ-006 Port: req_ready  out  1  controller can accept a request.
REQ-007 Port: req_addr  in  7  target register address.
REQ-008 Port: req_data  in  8  register write data.
REQ-009 Port: done  out  1  one-cycle pulse when a frame completes.
REQ-010 Port: err  out  1  one-cycle pulse when a request is rejected.
REQ-011 Port: sclk  out  1  SPI clock; idles low (mode 0).
REQ-012 Port: nCS  out  1  chip select, active low.
REQ-013 Port: COPI  out  1  serial data to the peripheral.

Function
REQ-014 Handshake: a request is accepted in a cycle where req_valid and req_ready are both 1; addr and data are captured in that cycle.
REQ-015 req_ready = 1 only in state IDLE; req_ready is combinational from state.
REQ-016 An accepted request with req_addr > MAX_ADDR sends no frame: err pulses 1 cycle later, the controller stays in IDLE, and req_ready stays 1.
REQ-017 An accepted in-range request loads shift_reg = {1'b1, req_addr, req_data} (16 bits) and enters SETUP.
REQ-018 States: IDLE, SETUP, SHIFT, HOLD, GAP. A half-period counter (0..CLK_DIV-1) paces SETUP, SHIFT, HOLD and GAP.
REQ-019 SETUP: nCS=0, sclk=0, COPI=shift_reg[15]; lasts 1 half-period, then goes to SHIFT.
REQ-020 SHIFT: sclk toggles each half-period, giving 16 rising and 16 falling edges in total.
REQ-021 SHIFT, rising edge: COPI holds steady.
REQ-022 SHIFT, falling edges 1..15: shift_reg shifts left and COPI takes the next bit, MSB first.
REQ-023 SHIFT, 16th falling edge: sclk=0 and the state goes to HOLD.
REQ-024 HOLD: nCS=0, sclk=0 for 1 half-period.
REQ-025 Leaving HOLD: nCS=1, done pulses in the same cycle, and the state goes to GAP.
REQ-026 GAP: nCS=1 for GAP_HALVES half-periods, then IDLE; requests are not accepted during GAP.
REQ-027 Latency: done asserts exactly 34*CLK_DIV cycles after the accept cycle.
REQ-028 Latency: the next accept is possible at the earliest (34+GAP_HALVES)*CLK_DIV+1 cycles after the previous accept.
REQ-029 A bit counter (0..16) counts falling edges; the state leaves SHIFT only when it reaches 16.
REQ-030 Counter widths are sized from the parameters; no counter wraps in legal use.
REQ-031 While nCS=0, sclk and COPI never change in the same cycle.
REQ-032 req_valid may drop at any time without effect once the request has been accepted.

Reset
REQ-033 rst_n low forces, asynchronously: state=IDLE, sclk=0, nCS=1, COPI=0, done=0, err=0, all counters=0, shift_reg=0.
REQ-034 Reset during a frame aborts it immediately (nCS high); no done pulse is generated for the aborted frame.
REQ-035 req_ready=1 in the first cycle after rst_n rises.

Structure
REQ-036 A shared package spi_pkg holds: MAX_ADDR=4, ADDR_W=7, DATA_W=8, FRAME_W=16, WRITE_BIT=1, and the state enum type.
REQ-037 The peripheral-side receiver imports the same spi_pkg constants.
REQ-038 One sub-module, spi_clk_gen, contains the half-period counter; it emits a tick pulse and the edge type (rise/fall) to the FSM.

Verification
REQ-039 Scenario 1: addr=0x00, data=0xA5, CLK_DIV=4 -> COPI sampled at sclk rises = 0x80A5; done at accept+136 cycles.
REQ-040 Scenario 2: addr=0x04, data=0xFF, then the receiver model is checked -> receiver register 4 = 0xFF; exactly 16 sclk rises are seen.
REQ-041 Scenario 3: addr=0x05, data=0x12 -> err pulse 1 cycle after accept; nCS never low; done=0.
REQ-042 Scenario 4: req_valid held high with 2 in-range requests queued back to back -> second nCS fall occurs no earlier than GAP_HALVES*CLK_DIV=8 cycles after the first nCS rise.
REQ-043 Scenario 5: rst_n pulsed low after the 7th sclk rise -> nCS=1 and sclk=0 asynchronously; no done pulse; the next request completes normally.
REQ-044 Scenario 6: CLK_DIV=2, addr=0x03, data=0x3C -> frame 0x833C is received correctly; the sclk period is 4 cycles.
